// File: rtl/bus_source_driver.sv
// Drives the shared bus from one of R0..R7, G or DIN for HOLD_CYC cycles per accepted request.
// Optional build macro BUS_KEEPER_EN: bus keeps its last driven value while idle.
//
// state | meaning
// IDLE  | bus released, ready to accept a request
// DRIVE | buswires valid; cnt_q counts hold cycles, last cycle may re-accept
module bus_source_driver #(
    parameter int WIDTH    = 16,
    parameter int NSRC     = 10,
    parameter int HOLD_CYC = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [8*WIDTH-1:0] r_src,
    input  logic [WIDTH-1:0]   g_src,
    input  logic [WIDTH-1:0]   din,
    input  logic [NSRC-1:0]    sel,
    input  logic               drive_req,
    output logic               drive_ready,
    output logic [WIDTH-1:0]   buswires,
    output logic               bus_valid,
    output logic               sel_err
);

    typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} state_t;

    localparam logic [3:0] LAST_CNT = 4'(HOLD_CYC - 1);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   bus_q, bus_d;
    logic               err_q, err_d;

    logic [3:0]         sel_ones;
    logic               sel_ok;
    logic [WIDTH-1:0]   sel_pick;
    logic [WIDTH-1:0]   sel_data;
    logic               last_cyc;
    logic               accept;

    // AND-OR mux; a multi-hot select would mix sources, so it is forced to 0 below
    always_comb begin
        sel_ones = '0;
        sel_pick = '0;
        for (int i = 0; i < NSRC; i++) begin
            sel_ones = sel_ones + {3'b000, sel[i]};
        end
        for (int i = 0; i < 8; i++) begin
            if (sel[i]) sel_pick = sel_pick | r_src[i*WIDTH +: WIDTH];
        end
        if (sel[8]) sel_pick = sel_pick | g_src;
        if (sel[9]) sel_pick = sel_pick | din;
        sel_ok   = (sel_ones == 4'd1);
        sel_data = sel_ok ? sel_pick : '0;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_d       = bus_q;
        err_d       = err_q;
        last_cyc    = (state_q == DRIVE) && (cnt_q == LAST_CNT);
        drive_ready = !reset && ((state_q == IDLE) || last_cyc);
        accept      = drive_req && drive_ready;

        if (accept) begin
            state_d = DRIVE;
            cnt_d   = '0;
            bus_d   = sel_data;
            if (!sel_ok) err_d = 1'b1;
        end else if (state_q == DRIVE) begin
            if (last_cyc) begin
                state_d = IDLE;
                cnt_d   = '0;
`ifdef BUS_KEEPER_EN
                bus_d   = bus_q;
`else
                bus_d   = '0;
`endif
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bus_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bus_q   <= bus_d;
            err_q   <= err_d;
        end
    end

    assign buswires  = bus_q;
    assign bus_valid = (state_q == DRIVE);
    assign sel_err   = err_q;

endmodule

// File: tb/tb_bus_source_driver.sv
// Randomized plus directed bench for bus_source_driver at HOLD_CYC = 1, 3 and 4,
// checked against a remaining-cycles reference model.
module tb_bus_source_driver;

    localparam int W  = 16;
    localparam int N  = 10;
    localparam int NH = 3;

    logic             clk;
    logic             reset;
    logic [8*W-1:0]   r_src;
    logic [W-1:0]     g_src;
    logic [W-1:0]     din;
    logic [N-1:0]     sel;
    logic             drive_req;

    logic             rdy_o [NH];
    logic [W-1:0]     bus_o [NH];
    logic             val_o [NH];
    logic             err_o [NH];

    int               hold  [NH];
    int               left  [NH];
    logic [W-1:0]     mbus  [NH];
    logic             merr  [NH];

    int               n_vec;
    int               n_err;

    bus_source_driver #(.WIDTH(W), .NSRC(N), .HOLD_CYC(1)) u_h1 (
        .clk(clk), .reset(reset), .r_src(r_src), .g_src(g_src), .din(din), .sel(sel),
        .drive_req(drive_req), .drive_ready(rdy_o[0]), .buswires(bus_o[0]),
        .bus_valid(val_o[0]), .sel_err(err_o[0]));

    bus_source_driver #(.WIDTH(W), .NSRC(N), .HOLD_CYC(3)) u_h3 (
        .clk(clk), .reset(reset), .r_src(r_src), .g_src(g_src), .din(din), .sel(sel),
        .drive_req(drive_req), .drive_ready(rdy_o[1]), .buswires(bus_o[1]),
        .bus_valid(val_o[1]), .sel_err(err_o[1]));

    bus_source_driver #(.WIDTH(W), .NSRC(N), .HOLD_CYC(4)) u_h4 (
        .clk(clk), .reset(reset), .r_src(r_src), .g_src(g_src), .din(din), .sel(sel),
        .drive_req(drive_req), .drive_ready(rdy_o[2]), .buswires(bus_o[2]),
        .bus_valid(val_o[2]), .sel_err(err_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] source_of(input logic [N-1:0] s, input logic [8*W-1:0] r,
                                                input logic [W-1:0] g, input logic [W-1:0] d);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (s[i]) begin
                if (i < 8)       v = r[i*W +: W];
                else if (i == 8) v = g;
                else             v = d;
            end
        end
        return v;
    endfunction

    // Apply one cycle of inputs just after a falling edge, check, then advance the model.
    task automatic step(input logic rst, input logic req, input logic [N-1:0] s,
                        input logic [8*W-1:0] r, input logic [W-1:0] g, input logic [W-1:0] d,
                        input bit do_chk);
        logic ok;
        logic exp_rdy [NH];
        reset = rst; drive_req = req; sel = s; r_src = r; g_src = g; din = d;
        #1;
        for (int k = 0; k < NH; k++) begin
            exp_rdy[k] = !rst && (left[k] <= 1);
            if (do_chk) begin
                chk($sformatf("ready[h%0d]", hold[k]), 32'(rdy_o[k]), 32'(exp_rdy[k]));
                chk($sformatf("valid[h%0d]", hold[k]), 32'(val_o[k]), 32'(left[k] > 0));
                chk($sformatf("bus[h%0d]",   hold[k]), 32'(bus_o[k]), 32'(mbus[k]));
                chk($sformatf("err[h%0d]",   hold[k]), 32'(err_o[k]), 32'(merr[k]));
            end
        end
        @(posedge clk);
        ok = ($countones(s) == 1);
        for (int k = 0; k < NH; k++) begin
            if (rst) begin
                left[k] = 0; mbus[k] = '0; merr[k] = 1'b0;
            end else if (req && exp_rdy[k]) begin
                left[k] = hold[k];
                mbus[k] = ok ? source_of(s, r, g, d) : '0;
                if (!ok) merr[k] = 1'b1;
            end else if (left[k] > 0) begin
                left[k]--;
`ifndef BUS_KEEPER_EN
                if (left[k] == 0) mbus[k] = '0;
`endif
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, r_src, g_src, din, 1'b1);
    endtask

    logic [8*W-1:0] rv;
    logic [N-1:0]   rs;

    initial begin
        n_vec = 0; n_err = 0;
        hold[0] = 1; hold[1] = 3; hold[2] = 4;
        for (int k = 0; k < NH; k++) begin left[k] = 0; mbus[k] = '0; merr[k] = 1'b0; end
        reset = 1'b1; drive_req = 1'b0; sel = '0; r_src = '0; g_src = '0; din = '0;
        @(negedge clk);
        step(1'b1, 1'b0, '0, '0, '0, '0, 1'b0);
        step(1'b1, 1'b0, '0, '0, '0, '0, 1'b1);

        // single R2 transfer
        rv = '0; rv[2*W +: W] = 16'hABCD;
        step(1'b0, 1'b1, 10'b0000000100, rv, '0, '0, 1'b1);
        chk("r2_bus", 32'(bus_o[0]), 32'h0000ABCD);
        chk("r2_valid", 32'(val_o[0]), 32'd1);
        idle(1);
        chk("r2_valid_drop", 32'(val_o[0]), 32'd0);
        idle(4);

        // G snapshot held for 3 cycles despite source change
        step(1'b0, 1'b1, 10'b0100000000, rv, 16'h1234, '0, 1'b1);
        chk("g_bus_c1", 32'(bus_o[1]), 32'h00001234);
        chk("g_ready_c1", 32'(rdy_o[1]), 32'd0);
        step(1'b0, 1'b0, '0, rv, 16'hFFFF, '0, 1'b1);
        chk("g_bus_c2", 32'(bus_o[1]), 32'h00001234);
        chk("g_ready_c2", 32'(rdy_o[1]), 32'd0);
        idle(1);
        chk("g_bus_c3", 32'(bus_o[1]), 32'h00001234);
        chk("g_ready_c3", 32'(rdy_o[1]), 32'd1);
        idle(5);

        // back-to-back DIN then R7
        step(1'b0, 1'b1, 10'b1000000000, rv, '0, 16'h0001, 1'b1);
        chk("b2b_bus1", 32'(bus_o[0]), 32'h00000001);
        rv = '0; rv[7*W +: W] = 16'h8000;
        step(1'b0, 1'b1, 10'b0010000000, rv, '0, 16'h0001, 1'b1);
        chk("b2b_bus2", 32'(bus_o[0]), 32'h00008000);
        chk("b2b_valid2", 32'(val_o[0]), 32'd1);
        idle(5);

        // multi-hot select, sticky error
        step(1'b0, 1'b1, 10'b0000000011, rv, '0, '0, 1'b1);
        chk("mh_bus", 32'(bus_o[0]), 32'd0);
        chk("mh_valid", 32'(val_o[0]), 32'd1);
        chk("mh_err", 32'(err_o[0]), 32'd1);
        idle(5);
        step(1'b0, 1'b1, 10'b0000000001, rv, '0, '0, 1'b1);
        idle(5);
        chk("mh_err_sticky", 32'(err_o[0]), 32'd1);
        step(1'b1, 1'b0, '0, rv, '0, '0, 1'b1);
        chk("mh_err_cleared", 32'(err_o[0]), 32'd0);

        // reset in the 2nd cycle of a HOLD_CYC=4 drive
        rv = '0; rv[1*W +: W] = 16'h7777;
        step(1'b0, 1'b1, 10'b0000000010, rv, '0, '0, 1'b1);
        idle(1);
        step(1'b1, 1'b0, '0, rv, '0, '0, 1'b1);
        chk("rst_bus", 32'(bus_o[2]), 32'd0);
        chk("rst_valid", 32'(val_o[2]), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_ready", 32'(rdy_o[2]), 32'd1);
        idle(2);

        // end-of-transfer bus value
        rv = '0; rv[5*W +: W] = 16'h5A5A;
        step(1'b0, 1'b1, 10'b0000100000, rv, '0, '0, 1'b1);
        idle(1);
`ifdef BUS_KEEPER_EN
        chk("keeper_bus", 32'(bus_o[0]), 32'h00005A5A);
`else
        chk("release_bus", 32'(bus_o[0]), 32'd0);
`endif
        idle(5);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            rs = '0;
            if ($urandom_range(0, 9) < 8) rs[$urandom_range(0, N-1)] = 1'b1;
            else                          rs = N'($urandom);
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 60), rs,
                 {$urandom, $urandom, $urandom, $urandom}, W'($urandom), W'($urandom), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
